// File: rtl/ling_knowles_sub_pipe.sv
// ling_knowles_sub_pipe: two-stage 22-bit Ling/Knowles prefix subtractor with valid/ready handshake.
// Define LING_SUB_SAT_EN for unsigned saturation (diff clamps to 0 on borrow) and the sat output.
module ling_knowles_sub_pipe #(
  parameter int WIDTH         = 22,
  parameter int STAGE1_LEVELS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef LING_SUB_SAT_EN
  ,
  output logic             sat
`endif
);
  localparam int LEVELS = $clog2(WIDTH);

  // One Knowles level: (H,I)[k] o (H,I)[k-s]
  function automatic logic [2*WIDTH-1:0] ks_lvl(input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] i, input int s);
    logic [WIDTH-1:0] ho, io;
    ho = h;
    io = i;
    for (int k = s; k < WIDTH; k++) begin
      ho[k] = h[k] | (i[k] & h[k-s]);
      io[k] = i[k] & i[k-s];
    end
    return {ho, io};
  endfunction

  logic             w_s1_adv, w_s2_adv, w_cin, w_cout;
  logic [WIDTH-1:0] w_p, w_g, w_h1, w_i1, w_h2, w_i2, w_c, w_s;
  logic             r_s1_valid, r_s2_valid, r_cin, r_bout;
  logic [WIDTH-1:0] r_p, r_g, r_h, r_i, r_diff;

  assign w_s2_adv = ~r_s2_valid | out_ready;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;
  assign in_ready = w_s1_adv;
  assign w_p      = a | ~b;
  assign w_g      = a & ~b;
  assign w_cin    = ~bin;

  // Leaf terms: H = g (carry-in folded into bit 0), I = p shifted up one bit
  always_comb begin
    w_h1 = {w_g[WIDTH-1:1], w_g[0] | w_cin};
    w_i1 = {w_p[WIDTH-2:0], 1'b0};
    for (int l = 0; l < STAGE1_LEVELS; l++) {w_h1, w_i1} = ks_lvl(w_h1, w_i1, 1 << l);
  end

  always_comb begin
    w_h2 = r_h;
    w_i2 = r_i;
    for (int l = STAGE1_LEVELS; l < LEVELS; l++) {w_h2, w_i2} = ks_lvl(w_h2, w_i2, 1 << l);
  end

  assign w_c    = {r_p[WIDTH-2:0] & w_h2[WIDTH-2:0], r_cin};
  assign w_s    = (r_p ^ w_h2) | (r_g & w_c);
  assign w_cout = r_p[WIDTH-1] & w_h2[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_p        <= '0;
      r_g        <= '0;
      r_cin      <= 1'b0;
      r_h        <= '0;
      r_i        <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_p   <= w_p;
        r_g   <= w_g;
        r_cin <= w_cin;
        r_h   <= w_h1;
        r_i   <= w_i1;
      end
    end
  end

`ifdef LING_SUB_SAT_EN
  logic r_sat;
  assign sat = r_sat;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sat <= 1'b0;
    else if (w_s2_adv && r_s1_valid) r_sat <= ~w_cout;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_diff     <= '0;
      r_bout     <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
`ifdef LING_SUB_SAT_EN
        r_diff <= w_cout ? w_s : '0;
`else
        r_diff <= w_s;
`endif
        r_bout <= ~w_cout;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
endmodule
